// File: rtl/cnn_lenet_udiv_17ns_10ns_8_seq_if.sv
// cnn_lenet_udiv_17ns_10ns_8_seq_if: start/done handshake, operands and results of the sequential divider
interface cnn_lenet_udiv_17ns_10ns_8_seq_if #(
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 8
);
  logic                  ap_start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  ap_idle;
  logic                  ap_done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] rem;
  logic                  div0;
  logic                  ovf;
  modport master (output ap_start, din0, din1, input ap_idle, ap_done, dout, rem, div0, ovf);
  modport slave  (input ap_start, din0, din1, output ap_idle, ap_done, dout, rem, div0, ovf);
endinterface

// File: rtl/cnn_lenet_udiv_17ns_10ns_8_seq.sv
// cnn_lenet_udiv_17ns_10ns_8_seq: restoring divider, one quotient bit per clock, start/done handshake
// Define CNN_LENET_UDIV_ROUND_EN to round the quotient to nearest (saturating at all-ones).
module cnn_lenet_udiv_17ns_10ns_8_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 8
) (
  input logic ap_clk,
  input logic ap_rst,
  cnn_lenet_udiv_17ns_10ns_8_seq_if.slave bus
);
  localparam int CW = (dout_WIDTH > 1) ? $clog2(dout_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  if (din0_WIDTH > din1_WIDTH + dout_WIDTH) begin : g_bad_widths
    $error("udiv instance %0d: dividend wider than divisor+quotient", ID);
  end
  state_t                state_q, state_d;
  logic [din1_WIDTH-1:0] dvs_q, par_q, par_n, rem_q;
  logic [dout_WIDTH-1:0] num_q, quo_q, quo_n, dout_q, q_fin;
  logic [din1_WIDTH:0]   sh;
  logic [CW-1:0]         cnt_q;
  logic                  div0_q, ovf_q, ge, zero, big, last, accept;
  assign accept = state_q == IDLE && bus.ap_start;
  assign zero   = bus.din1 == '0;
  assign big    = 32'(bus.din0) >= (32'(bus.din1) << dout_WIDTH);
  assign last   = state_q == CALC && cnt_q == CW'(dout_WIDTH - 1);
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = accept ? ((zero || big) ? DONE : CALC) :
              state_q == CALC ? (last ? DONE : CALC) :
              state_q == DONE ? IDLE : state_q;
  always_comb begin
    bus.ap_idle = state_q == IDLE;
    bus.ap_done = state_q == DONE;
    bus.dout    = dout_q;
    bus.rem     = rem_q;
    bus.div0    = div0_q;
    bus.ovf     = ovf_q;
  end
  // partial remainder always stays below the divisor, so the shifted value fits one extra bit
  always_comb begin
    sh    = {par_q, num_q[dout_WIDTH-1]};
    ge    = sh >= {1'b0, dvs_q};
    par_n = din1_WIDTH'(ge ? sh - {1'b0, dvs_q} : sh);
    quo_n = {quo_q[dout_WIDTH-2:0], ge};
  end
`ifdef CNN_LENET_UDIV_ROUND_EN
  assign q_fin = ({par_n, 1'b0} >= {1'b0, dvs_q}) && !(&quo_n) ? quo_n + 1'b1 : quo_n;
`else
  assign q_fin = quo_n;
`endif
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      dvs_q  <= '0;
      par_q  <= '0;
      num_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      rem_q  <= '0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      dvs_q  <= bus.din1;
      par_q  <= din1_WIDTH'(bus.din0 >> dout_WIDTH);
      num_q  <= bus.din0[dout_WIDTH-1:0];
      quo_q  <= '0;
      cnt_q  <= '0;
      div0_q <= zero;
      ovf_q  <= !zero && big;
      if (zero || big) begin
        dout_q <= '1;
        rem_q  <= zero ? din1_WIDTH'(bus.din0) : bus.din1 - 1'b1;
      end
    end else if (state_q == CALC) begin
      par_q <= par_n;
      quo_q <= quo_n;
      num_q <= num_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        dout_q <= q_fin;
        rem_q  <= par_n;
      end
    end
endmodule

// File: tb/tb_cnn_lenet_udiv_17ns_10ns_8_seq.sv
// tb_cnn_lenet_udiv_17ns_10ns_8_seq: directed and random checks of the sequential divider against an arithmetic model
module tb_cnn_lenet_udiv_17ns_10ns_8_seq;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] prev_q = '0;
  logic [9:0] prev_r = '0;
  cnn_lenet_udiv_17ns_10ns_8_seq_if bus ();
  cnn_lenet_udiv_17ns_10ns_8_seq dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));
  always #5 ap_clk = ~ap_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic void model(input int n, input int d, output int q, output int r,
                                output bit z, output bit o);
    z = d == 0;
    o = !z && n >= d * 256;
    if (z) begin q = 255; r = n % 1024; end
    else if (o) begin q = 255; r = d - 1; end
    else begin
      q = n / d;
      r = n % d;
`ifdef CNN_LENET_UDIV_ROUND_EN
      if (2 * r >= d && q < 255) q++;
`endif
    end
  endfunction
  task automatic run_op(input int n, input int d, input bit pulse);
    int q, r, edges, lat;
    bit z, o;
    model(n, d, q, r, z, o);
    lat = (z || o) ? 1 : 9;
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.din0 = 17'(n);
    bus.din1 = 10'(d);
    @(posedge ap_clk);
    edges = 1;
    #1;
    bus.ap_start = 1'b0;
    bus.din0 = 17'($urandom);
    bus.din1 = 10'($urandom);
    @(negedge ap_clk);
    check("busy_not_idle", 32'(bus.ap_idle), 0);
    if (lat == 9) begin
      check("hold_dout", 32'(bus.dout), 32'(prev_q));
      check("hold_rem", 32'(bus.rem), 32'(prev_r));
    end
    while (!bus.ap_done && edges < 20) begin
      bus.ap_start = pulse && edges == 3;
      @(posedge ap_clk);
      edges++;
      @(negedge ap_clk);
    end
    bus.ap_start = 1'b0;
    check("latency", 32'(edges), 32'(lat));
    check("dout", 32'(bus.dout), 32'(q));
    check("rem", 32'(bus.rem), 32'(r));
    check("div0", 32'(bus.div0), 32'(z));
    check("ovf", 32'(bus.ovf), 32'(o));
`ifndef CNN_LENET_UDIV_ROUND_EN
    if (!z && !o) check("invariant", 32'(bus.dout) * 32'(d) + 32'(bus.rem), 32'(n));
`endif
    prev_q = 8'(q);
    prev_r = 10'(r);
    @(negedge ap_clk);
    check("done_one_cycle", 32'(bus.ap_done), 0);
    check("back_idle", 32'(bus.ap_idle), 1);
  endtask
  task automatic abort_op();
    int seen = 0;
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.din0 = 17'd1000;
    bus.din1 = 10'd10;
    @(posedge ap_clk);
    #1 bus.ap_start = 1'b0;
    repeat (4) @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check("abort_idle", 32'(bus.ap_idle), 1);
    check("abort_done", 32'(bus.ap_done), 0);
    check("abort_dout", 32'(bus.dout), 0);
    check("abort_rem", 32'(bus.rem), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (12) begin
      @(negedge ap_clk);
      if (bus.ap_done) seen++;
    end
    check("abort_no_done", 32'(seen), 0);
    prev_q = '0;
    prev_r = '0;
  endtask
  initial begin
    int n, d, mode;
    bus.ap_start = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_idle", 32'(bus.ap_idle), 1);
    check("rst_done", 32'(bus.ap_done), 0);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_rem", 32'(bus.rem), 0);
    check("rst_div0", 32'(bus.div0), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    ap_rst = 1'b0;
    run_op(1000, 10, 1'b1);
    run_op(131071, 1023, 1'b0);
    run_op(5, 7, 1'b0);
    run_op(300, 0, 1'b0);
    run_op(2560, 10, 1'b0);
    run_op(2549, 10, 1'b1);
    run_op(25, 10, 1'b0);
    run_op(0, 1, 1'b0);
    abort_op();
    run_op(1000, 10, 1'b0);
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        d = 0;
        n = $urandom_range(0, 131071);
      end else if (mode == 1) begin
        d = $urandom_range(1, 511);
        n = $urandom_range(d * 256, 131071);
      end else begin
        d = $urandom_range(1, 1023);
        n = $urandom_range(0, (d * 256 - 1 > 131071) ? 131071 : d * 256 - 1);
      end
      run_op(n, d, mode > 1 && $urandom_range(0, 3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
